hazard_scoreboard_ctrl: RTL and testbench

//  Pipeline stall/bubble controller for the 5-stage core; successor to the fixed load-use/store-load stall unit.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 42 ++++
 rtl/hazard_scoreboard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard control slice.
package hazard_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LOAD = 2'd1,
        MEM_STOR = 2'd2
    } mem_type_e;

    localparam int unsigned DEFAULT_MAX_LAT = 3;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register latency countdowns: two pending-read ports, one set port,
// and a global decrement/clear.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned LAT_W    = 2,
    localparam int unsigned REG_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rd_a_addr,
    input  logic [REG_W-1:0] rd_b_addr,
    output logic             rd_a_pend,
    output logic             rd_b_pend,
    input  logic             clear,
    input  logic             advance,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic [LAT_W-1:0] set_val
);

    logic [LAT_W-1:0] cnt [NUM_REGS];

    // A set on a register overrides its own decrement in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else if (clear) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (set_en && set_addr == REG_W'(r))
                    cnt[r] <= set_val;
                else if (advance && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    assign rd_a_pend = (cnt[rd_a_addr] != '0);
    assign rd_b_pend = (cnt[rd_b_addr] != '0);

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Stall/bubble controller beside ID: scoreboarded RAW hazards, store-load
// conflict, EX/MEM busy freezing, flush handling and a bubble counter.
module hazard_scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_LAT  = DEFAULT_MAX_LAT,
    parameter int unsigned PERF_W   = 32,
    localparam int unsigned REG_W   = $clog2(NUM_REGS),
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_valid,
    input  logic [REG_W-1:0]  de_rs,
    input  logic              de_rs_used,
    input  logic [REG_W-1:0]  de_rt,
    input  logic              de_rt_used,
    input  logic              de_wen,
    input  logic [REG_W-1:0]  de_rd,
    input  logic [LAT_W-1:0]  de_lat,
    input  logic [1:0]        de_mem_type,
    input  logic [1:0]        ex_mem_type,
    input  logic              ex_busy_i,
    input  logic              mem_busy_i,
    input  logic              flush_i,
    input  logic              exc_flush_i,
    output logic              if_stall_o,
    output logic              id_stall_o,
    output logic              ex_stall_o,
    output logic              mem_stall_o,
    output logic              ex_bubble_o,
    output logic [PERF_W-1:0] bubble_cnt_o
);

    logic             rs_pend;
    logic             rt_pend;
    logic             raw;
    logic             sl;
    logic             issue;
    logic             advance;
    logic             set_en;
    logic [LAT_W-1:0] lat_clip;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LAT_W    (LAT_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (de_rs),
        .rd_b_addr (de_rt),
        .rd_a_pend (rs_pend),
        .rd_b_pend (rt_pend),
        .clear     (exc_flush_i),
        .advance   (advance),
        .set_en    (set_en),
        .set_addr  (de_rd),
        .set_val   (lat_clip)
    );

    always_comb begin
        raw = de_valid & ((de_rs_used & (de_rs != '0) & rs_pend) |
                          (de_rt_used & (de_rt != '0) & rt_pend));
        sl  = de_valid & (de_mem_type == MEM_LOAD) & (ex_mem_type == MEM_STOR);

        mem_stall_o = mem_busy_i;
        ex_stall_o  = mem_busy_i;
        id_stall_o  = mem_busy_i | ex_busy_i;
        // A flush kills the ID instruction through the bubble, so no hazard hold.
        if_stall_o  = id_stall_o | ((raw | sl) & ~flush_i);
        ex_bubble_o = ~id_stall_o & (raw | sl | flush_i);

        issue    = de_valid & ~id_stall_o & ~raw & ~sl & ~flush_i;
        advance  = ~ex_busy_i & ~mem_busy_i;
        set_en   = issue & de_wen & (de_rd != '0);
        lat_clip = (de_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : de_lat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bubble_cnt_o <= '0;
        else     bubble_cnt_o <= bubble_cnt_o + PERF_W'(ex_bubble_o);
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl with an expected-result queue.
module tb_hazard_scoreboard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_valid, de_rs_used, de_rt_used, de_wen;
    logic [4:0]  de_rs, de_rt, de_rd;
    logic [1:0]  de_lat;
    logic [1:0]  de_mem_type, ex_mem_type;
    logic        ex_busy_i, mem_busy_i, flush_i, exc_flush_i;
    logic        if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, ex_bubble_o;
    logic [31:0] bubble_cnt_o;
    logic        w_if, w_id, w_ex, w_mem, w_bub;
    logic [3:0]  w_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] bcnt  = '0;

    typedef struct packed {
        logic        ifs;
        logic        ids;
        logic        exs;
        logic        mems;
        logic        bub;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl dut (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs(de_rs), .de_rs_used(de_rs_used),
        .de_rt(de_rt), .de_rt_used(de_rt_used), .de_wen(de_wen), .de_rd(de_rd), .de_lat(de_lat),
        .de_mem_type(de_mem_type), .ex_mem_type(ex_mem_type), .ex_busy_i(ex_busy_i),
        .mem_busy_i(mem_busy_i), .flush_i(flush_i), .exc_flush_i(exc_flush_i),
        .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .ex_stall_o(ex_stall_o),
        .mem_stall_o(mem_stall_o), .ex_bubble_o(ex_bubble_o), .bubble_cnt_o(bubble_cnt_o)
    );

    hazard_scoreboard_ctrl #(.PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs(de_rs), .de_rs_used(de_rs_used),
        .de_rt(de_rt), .de_rt_used(de_rt_used), .de_wen(de_wen), .de_rd(de_rd), .de_lat(de_lat),
        .de_mem_type(de_mem_type), .ex_mem_type(ex_mem_type), .ex_busy_i(ex_busy_i),
        .mem_busy_i(mem_busy_i), .flush_i(flush_i), .exc_flush_i(exc_flush_i),
        .if_stall_o(w_if), .id_stall_o(w_id), .ex_stall_o(w_ex),
        .mem_stall_o(w_mem), .ex_bubble_o(w_bub), .bubble_cnt_o(w_cnt)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        de_valid = 0; de_rs = '0; de_rs_used = 0; de_rt = '0; de_rt_used = 0;
        de_wen = 0; de_rd = '0; de_lat = '0; de_mem_type = MEM_NONE; ex_mem_type = MEM_NONE;
        ex_busy_i = 0; mem_busy_i = 0; flush_i = 0; exc_flush_i = 0;
    endtask

    task automatic producer(input logic [4:0] rd, input logic [1:0] lat, input logic [1:0] mt);
        idle();
        de_valid = 1; de_wen = 1; de_rd = rd; de_lat = lat; de_mem_type = mt;
    endtask

    task automatic consumer(input logic [4:0] rs);
        idle();
        de_valid = 1; de_rs = rs; de_rs_used = 1;
    endtask

    // Called just after a rising edge with inputs applied; samples mid-cycle, then advances one edge.
    task automatic chk(input string tag, input logic ifs, input logic ids, input logic mems,
                       input logic bub);
        exp_t e;
        exp_q.push_back('{ifs: ifs, ids: ids, exs: mems, mems: mems, bub: bub, cnt: bcnt});
        @(negedge clk);
        e = exp_q.pop_front();
        cmp({tag, ".if"},   32'(if_stall_o),   32'(e.ifs));
        cmp({tag, ".id"},   32'(id_stall_o),   32'(e.ids));
        cmp({tag, ".ex"},   32'(ex_stall_o),   32'(e.exs));
        cmp({tag, ".mem"},  32'(mem_stall_o),  32'(e.mems));
        cmp({tag, ".bub"},  32'(ex_bubble_o),  32'(e.bub));
        cmp({tag, ".cnt"},  bubble_cnt_o,      e.cnt);
        cmp({tag, ".cnt4"}, 32'(w_cnt),        32'(e.cnt[3:0]));
        @(posedge clk);
        #1;
        bcnt = bcnt + 32'(bub);
    endtask

    initial begin
        rst = 1;
        idle();
        @(posedge clk); #1;
        chk("reset", 0, 0, 0, 0);
        rst = 0;
        chk("idle", 0, 0, 0, 0);

        // load r5 lat 1, then consumer of r5
        producer(5'd5, 2'd1, MEM_LOAD);        chk("t1_ld", 0, 0, 0, 0);
        consumer(5'd5); ex_mem_type = MEM_LOAD; chk("t1_raw", 1, 0, 0, 1);
        chk("t1_iss", 0, 0, 0, 0);
        idle();                                chk("t1_idle", 0, 0, 0, 0);

        // mul r8 lat 3, consumer waits through two mem_busy cycles
        producer(5'd8, 2'd3, MEM_NONE);        chk("t2_mul", 0, 0, 0, 0);
        consumer(5'd8);                        chk("t2_b1", 1, 0, 0, 1);
        mem_busy_i = 1;                        chk("t2_busy1", 1, 1, 1, 0);
                                               chk("t2_busy2", 1, 1, 1, 0);
        mem_busy_i = 0;                        chk("t2_b2", 1, 0, 0, 1);
                                               chk("t2_b3", 1, 0, 0, 1);
                                               chk("t2_iss", 0, 0, 0, 0);

        // writes to r0 and unused sources never stall
        producer(5'd0, 2'd3, MEM_NONE);        chk("t3_r0w", 0, 0, 0, 0);
        consumer(5'd0);                        chk("t3_r0r", 0, 0, 0, 0);
        producer(5'd9, 2'd3, MEM_NONE);        chk("t3_r9w", 0, 0, 0, 0);
        consumer(5'd1); de_rt = 5'd9;          chk("t3_rtoff", 0, 0, 0, 0);
        idle(); ex_busy_i = 1;                 chk("t3_exbusy", 1, 1, 0, 0);

        // store-load conflict
        idle(); de_valid = 1; de_mem_type = MEM_LOAD; ex_mem_type = MEM_STOR;
                                               chk("t4_sl", 1, 0, 0, 1);
        ex_mem_type = MEM_NONE;                chk("t4_sl_iss", 0, 0, 0, 0);
        ex_mem_type = MEM_NONE;                chk("t4_ld_alu", 0, 0, 0, 0);
        de_valid = 0; ex_mem_type = MEM_STOR;  chk("t4_inval", 0, 0, 0, 0);

        // exception flush clears the scoreboard; branch flush overrides raw
        producer(5'd5, 2'd2, MEM_NONE);        chk("t5_set", 0, 0, 0, 0);
        idle(); exc_flush_i = 1;               chk("t5_exc", 0, 0, 0, 0);
        consumer(5'd5);                        chk("t5_noraw", 0, 0, 0, 0);
        producer(5'd7, 2'd2, MEM_NONE);        chk("t5_set7", 0, 0, 0, 0);
        consumer(5'd7); flush_i = 1;           chk("t5_flush", 0, 0, 0, 1);
        idle();                                chk("t5_idle", 0, 0, 0, 0);

        // async reset mid-countdown
        producer(5'd10, 2'd3, MEM_NONE);       chk("t6_set", 0, 0, 0, 0);
        consumer(5'd10);
        #2;
        cmp("t6_pre_bub", 32'(ex_bubble_o), 32'd1);
        rst = 1;
        #1;
        cmp("t6_rst_if",  32'(if_stall_o),  32'd0);
        cmp("t6_rst_bub", 32'(ex_bubble_o), 32'd0);
        cmp("t6_rst_cnt", bubble_cnt_o,     32'd0);
        bcnt = '0;
        @(posedge clk); #1;
        rst = 0;
        chk("t6_release", 0, 0, 0, 0);

        // 16 bubbles wrap the 4-bit counter
        idle(); de_valid = 1; flush_i = 1;
        for (int i = 0; i < 16; i++) chk("wrap", 0, 0, 0, 1);
        idle();
        @(negedge clk);
        cmp("wrap4_zero", 32'(w_cnt),  32'd0);
        cmp("cnt32_16",   bubble_cnt_o, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
